// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory controller.
// MMIO decode is only used when LC3_MMIO_EN is defined.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone,
    StHold
  } state_e;

  typedef enum logic [1:0] {
    MmioKbsr,
    MmioKbdr,
    MmioDsr,
    MmioDdr
  } mmio_sel_e;

  typedef struct packed {
    logic      hit;
    mmio_sel_e sel;
  } mmio_dec_t;

  localparam logic [15:0] KbsrAddr    = 16'hFE00;
  localparam logic [15:0] KbdrAddr    = 16'hFE02;
  localparam logic [15:0] DsrAddr     = 16'hFE04;
  localparam logic [15:0] DdrAddr     = 16'hFE06;
  localparam logic [15:0] DsrReadyVal = 16'h8000;

  function automatic mmio_dec_t mmio_decode(input logic [15:0] addr);
    mmio_dec_t dec;
    dec.hit = 1'b1;
    dec.sel = MmioKbsr;
    unique case (addr)
      KbsrAddr: dec.sel = MmioKbsr;
      KbdrAddr: dec.sel = MmioKbdr;
      DsrAddr:  dec.sel = MmioDsr;
      DdrAddr:  dec.sel = MmioDdr;
      default:  dec.hit = 1'b0;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/lc3_mem_array.sv
// Single-port 16-bit synchronous RAM: one write port, registered read data.
// Storage is never reset; only the read register is.
module lc3_mem_array #(
  parameter int unsigned AddrBits = 12
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic                re_i,
  input  logic [AddrBits-1:0] addr_i,
  input  logic [15:0]         wdata_i,
  output logic [15:0]         rdata_o
);

  logic [15:0] mem_q [2**AddrBits];
  logic [15:0] rdata_q, rdata_d;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: latency-programmable access FSM in front of lc3_mem_array.
// Define LC3_MMIO_EN to decode the keyboard/display registers at xFE00..xFE06.
module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int unsigned MEM_LAT   = 3,
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CS,
  input  logic        WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] WDATA,
  output logic [15:0] RDATA,
  output logic        READY,
  input  logic [7:0]  KB_DATA,
  input  logic        KB_VALID,
  output logic [7:0]  DISP_DATA,
  output logic        DISP_VALID
);

  localparam logic [3:0] LatLoad = 4'(MEM_LAT - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]  idx_q, idx_d;
  logic                  we_q, we_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  mmio_q, mmio_d;
  mmio_sel_e             msel_q, msel_d;

  mmio_dec_t             dec;
  logic                  last_busy;
  logic                  done;
  logic                  arr_we;
  logic                  arr_re;
  logic [15:0]           arr_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    mmio_d  = mmio_q;
    msel_d  = msel_q;
    unique case (state_q)
      StIdle: begin
        if (CS) begin
          idx_d   = ADDR[ADDR_BITS-1:0];
          we_d    = WE;
          wdata_d = WDATA;
          mmio_d  = dec.hit;
          msel_d  = dec.sel;
          cnt_d   = dec.hit ? 4'd0 : LatLoad;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!CS) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: state_d = StHold;
      StHold: begin
        if (!CS) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      mmio_q  <= 1'b0;
      msel_q  <= MmioKbsr;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      mmio_q  <= mmio_d;
      msel_q  <= msel_d;
    end
  end

  // Read is launched one cycle early so the registered data is valid during DONE.
  assign last_busy = (state_q == StBusy) && CS && (cnt_q == 4'd0);
  assign done      = (state_q == StDone);
  assign arr_re    = last_busy && !we_q && !mmio_q;
  assign arr_we    = done && we_q && !mmio_q;
  assign READY     = done;

  lc3_mem_array #(
    .AddrBits (ADDR_BITS)
  ) u_array (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

`ifdef LC3_MMIO_EN
  logic        kb_ready_q, kb_ready_d;
  logic [7:0]  kbdr_q, kbdr_d;
  logic [7:0]  disp_data_q, disp_data_d;
  logic        disp_valid_q, disp_valid_d;
  logic [15:0] mmio_rdata_q, mmio_rdata_d;
  logic        rsel_q, rsel_d;

  assign dec = mmio_decode(ADDR);

  always_comb begin
    kb_ready_d   = kb_ready_q;
    kbdr_d       = kbdr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = 1'b0;
    mmio_rdata_d = mmio_rdata_q;
    rsel_d       = rsel_q;
    if (last_busy && !we_q) begin
      rsel_d = mmio_q;
      if (mmio_q) begin
        unique case (msel_q)
          MmioKbsr: mmio_rdata_d = {kb_ready_q, 15'b0};
          MmioKbdr: mmio_rdata_d = {8'h00, kbdr_q};
          MmioDsr:  mmio_rdata_d = DsrReadyVal;
          MmioDdr:  mmio_rdata_d = {8'h00, disp_data_q};
        endcase
      end
    end
    if (done && mmio_q && !we_q && (msel_q == MmioKbdr)) begin
      kb_ready_d = 1'b0;
    end
    if (done && mmio_q && we_q && (msel_q == MmioDdr)) begin
      disp_data_d  = wdata_q[7:0];
      disp_valid_d = 1'b1;
    end
    // A new key in the same cycle as a KBDR read keeps the ready flag set.
    if (KB_VALID) begin
      kbdr_d     = KB_DATA;
      kb_ready_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      kb_ready_q   <= 1'b0;
      kbdr_q       <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      mmio_rdata_q <= '0;
      rsel_q       <= 1'b0;
    end else begin
      kb_ready_q   <= kb_ready_d;
      kbdr_q       <= kbdr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      mmio_rdata_q <= mmio_rdata_d;
      rsel_q       <= rsel_d;
    end
  end

  assign RDATA      = rsel_q ? mmio_rdata_q : arr_rdata;
  assign DISP_DATA  = disp_data_q;
  assign DISP_VALID = disp_valid_q;
`else
  logic unused_sigs;

  assign dec         = '{hit: 1'b0, sel: MmioKbsr};
  assign RDATA       = arr_rdata;
  assign DISP_DATA   = 8'h00;
  assign DISP_VALID  = 1'b0;
  assign unused_sigs = ^{KB_DATA, KB_VALID, ADDR, msel_q};
`endif

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed, table-driven bench for lc3_mem_ctrl (MEM_LAT=3, ADDR_BITS=12).
// Keyboard/display checks run only when LC3_MMIO_EN is defined.
module tb_lc3_mem_ctrl;
  import lc3_mem_pkg::*;

  localparam int unsigned MemLat = 3;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        CS;
  logic        WE;
  logic [15:0] ADDR;
  logic [15:0] WDATA;
  logic [15:0] RDATA;
  logic        READY;
  logic [7:0]  KB_DATA;
  logic        KB_VALID;
  logic [7:0]  DISP_DATA;
  logic        DISP_VALID;

  int n_checks = 0;
  int n_fail   = 0;

  lc3_mem_ctrl #(
    .MEM_LAT   (MemLat),
    .ADDR_BITS (12)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .CS         (CS),
    .WE         (WE),
    .ADDR       (ADDR),
    .WDATA      (WDATA),
    .RDATA      (RDATA),
    .READY      (READY),
    .KB_DATA    (KB_DATA),
    .KB_VALID   (KB_VALID),
    .DISP_DATA  (DISP_DATA),
    .DISP_VALID (DISP_VALID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Counts negedges after the accept edge until READY is seen; 99 on timeout.
  task automatic wait_ready(output int lat);
    lat = 99;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (READY) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        output logic [15:0] rdata, output int lat);
    @(negedge CLK);
    CS    = 1'b1;
    WE    = we;
    ADDR  = addr;
    WDATA = wdata;
    @(posedge CLK);
    #1;
    // Disturb the bus after accept; the latched values must be used.
    ADDR  = ~addr;
    WDATA = ~wdata;
    WE    = ~we;
    wait_ready(lat);
    rdata = RDATA;
    CS    = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
  endtask

  initial begin
    logic [15:0] rd;
    int          lat;
    int          cnt;
    logic [7:0]  seen;

    CS = 0; WE = 0; ADDR = 0; WDATA = 0; KB_DATA = 0; KB_VALID = 0;
    RESET_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset READY", {31'b0, READY}, 32'd0);
    check("reset RDATA", {16'b0, RDATA}, 32'd0);
    check("reset DISP_VALID", {31'b0, DISP_VALID}, 32'd0);
    check("reset DISP_DATA", {24'b0, DISP_DATA}, 32'd0);
    check("reset state", 32'(dut.state_q), 32'(StIdle));
    @(negedge CLK);
    RESET_N = 1'b1;

    vecs[0] = '{we: 1'b1, addr: 16'h0040, wdata: 16'h1234, exp: 16'h0000};
    vecs[1] = '{we: 1'b0, addr: 16'h0040, wdata: 16'h0000, exp: 16'h1234};
    vecs[2] = '{we: 1'b1, addr: 16'h1005, wdata: 16'hBEEF, exp: 16'h0000};
    vecs[3] = '{we: 1'b0, addr: 16'h0005, wdata: 16'h0000, exp: 16'hBEEF};
    vecs[4] = '{we: 1'b1, addr: 16'h0010, wdata: 16'h5555, exp: 16'h0000};
    vecs[5] = '{we: 1'b1, addr: 16'h0FFF, wdata: 16'hCAFE, exp: 16'h0000};
    vecs[6] = '{we: 1'b0, addr: 16'h0FFF, wdata: 16'h0000, exp: 16'hCAFE};
    vecs[7] = '{we: 1'b0, addr: 16'hF040, wdata: 16'h0000, exp: 16'h1234};
    vecs[8] = '{we: 1'b0, addr: 16'h0010, wdata: 16'h0000, exp: 16'h5555};

    foreach (vecs[i]) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
      check($sformatf("vec%0d latency", i), lat, MemLat + 1);
      if (!vecs[i].we) check($sformatf("vec%0d rdata", i), {16'b0, rd}, {16'b0, vecs[i].exp});
    end

    // Abort: CS drops in the second BUSY cycle of a write.
    @(negedge CLK);
    CS = 1'b1; WE = 1'b1; ADDR = 16'h0010; WDATA = 16'hAAAA;
    @(posedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    CS = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge CLK);
      if (READY) cnt++;
    end
    check("abort READY count", cnt, 0);
    access(1'b0, 16'h0010, 16'h0000, rd, lat);
    check("abort old value", {16'b0, rd}, 32'h5555);

    // Held CS: no second READY until CS returns low.
    @(negedge CLK);
    CS = 1'b1; WE = 1'b0; ADDR = 16'h0040;
    @(posedge CLK);
    wait_ready(lat);
    check("held first latency", lat, MemLat + 1);
    cnt = 0;
    repeat (4) begin
      @(negedge CLK);
      if (READY) cnt++;
    end
    check("held READY count", cnt, 0);
    CS = 1'b0;
    @(posedge CLK);
    access(1'b0, 16'h0005, 16'h0000, rd, lat);
    check("held reaccess latency", lat, MemLat + 1);
    check("held reaccess rdata", {16'b0, rd}, 32'hBEEF);

    // Reset in BUSY during a write to a known location.
    access(1'b1, 16'h0020, 16'h1111, rd, lat);
    access(1'b0, 16'h0040, 16'h0000, rd, lat);
    @(negedge CLK);
    CS = 1'b1; WE = 1'b1; ADDR = 16'h0020; WDATA = 16'h2222;
    @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    check("rst-mid READY", {31'b0, READY}, 32'd0);
    check("rst-mid state", 32'(dut.state_q), 32'(StIdle));
    check("rst-mid RDATA", {16'b0, RDATA}, 32'd0);
    check("rst-mid counter", {28'b0, dut.cnt_q}, 32'd0);
    // Reset releases with a read already requested: accepted on the first edge.
    CS = 1'b1; WE = 1'b0; ADDR = 16'h0020;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    wait_ready(lat);
    check("post-reset latency", lat, MemLat + 1);
    check("rst-mid no commit", {16'b0, RDATA}, 32'h1111);
    CS = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    access(1'b0, 16'h0FFF, 16'h0000, rd, lat);
    check("array survives reset", {16'b0, rd}, 32'hCAFE);

`ifdef LC3_MMIO_EN
    @(negedge CLK);
    KB_DATA = 8'h41; KB_VALID = 1'b1;
    @(negedge CLK);
    KB_VALID = 1'b0;
    access(1'b0, 16'hFE00, 16'h0000, rd, lat);
    check("kbsr latency", lat, 2);
    check("kbsr set", {16'b0, rd}, 32'h8000);
    access(1'b0, 16'hFE02, 16'h0000, rd, lat);
    check("kbdr data", {16'b0, rd}, 32'h0041);
    access(1'b0, 16'hFE00, 16'h0000, rd, lat);
    check("kbsr cleared", {16'b0, rd}, 32'h0000);
    access(1'b0, 16'hFE04, 16'h0000, rd, lat);
    check("dsr value", {16'b0, rd}, 32'h8000);
    @(negedge CLK);
    CS = 1'b1; WE = 1'b1; ADDR = 16'hFE06; WDATA = 16'h0048;
    @(posedge CLK);
    cnt = 0;
    seen = 8'h00;
    repeat (8) begin
      @(negedge CLK);
      if (DISP_VALID) begin
        cnt++;
        seen = DISP_DATA;
      end
    end
    CS = 1'b0;
    check("disp valid pulses", cnt, 1);
    check("disp data", {24'b0, seen}, 32'h48);
    @(posedge CLK);
`else
    @(negedge CLK);
    KB_DATA = 8'h41; KB_VALID = 1'b1;
    @(negedge CLK);
    KB_VALID = 1'b0;
    access(1'b1, 16'hFE06, 16'h0048, rd, lat);
    check("no-mmio DISP_VALID", {31'b0, DISP_VALID}, 32'd0);
    check("no-mmio DISP_DATA", {24'b0, DISP_DATA}, 32'd0);
    access(1'b0, 16'h0E06, 16'h0000, rd, lat);
    check("no-mmio array map", {16'b0, rd}, 32'h0048);
    access(1'b0, 16'hFE00, 16'h0000, rd, lat);
    check("no-mmio kbsr latency", lat, MemLat + 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_mem_ctrl.md
LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_LAT, default 3, which is the access latency in cycles from request accept to READY; legal range 1..15.
REQ-002 The block SHALL have parameter ADDR_BITS, default 12, which sets the array depth to 2^ADDR_BITS words of 16 bits.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port CS, input, 1 bit: access request, held high by the initiator until READY.
REQ-006 The block SHALL have port WE, input, 1 bit: write when high, read when low; qualified by CS.
REQ-007 The block SHALL have port ADDR, input, 16 bits: the MAR value.
REQ-008 The block SHALL have port WDATA, input, 16 bits: the MDR value for writes.
REQ-009 The block SHALL have port RDATA, output, 16 bits: read data.
REQ-010 The block SHALL have port READY, output, 1 bit: access complete, a single-cycle pulse.
REQ-011 The block SHALL have ports KB_DATA (input, 8 bits), KB_VALID (input, 1 bit), DISP_DATA (output, 8 bits) and DISP_VALID (output, 1 bit), used only per REQ-027..030.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY, DONE and HOLD.
REQ-013 In IDLE with CS=1, the block SHALL latch ADDR, WE and WDATA, load the latency counter with MEM_LAT-1, and go to BUSY.
REQ-014 In BUSY, the counter SHALL decrement each cycle; at 0 the FSM goes to DONE.
REQ-015 In DONE, READY SHALL be 1 for exactly one cycle, after which the FSM goes to HOLD.
REQ-016 READY SHALL therefore rise MEM_LAT+1 cycles after the CS-accept edge.
REQ-017 In HOLD, the FSM SHALL return to IDLE when CS=0; a new access is never accepted without CS first returning low.
REQ-018 A write SHALL commit the latched WDATA to the latched address on the DONE cycle only.
REQ-019 On a read, RDATA SHALL be valid during DONE and held until the next read reaches DONE.
REQ-020 If CS falls while the FSM is in BUSY, the access SHALL be aborted: no write commits, READY stays 0, and the next state is IDLE.
REQ-021 The array index SHALL be ADDR[ADDR_BITS-1:0]; upper bits are ignored, so addresses wrap modulo the depth.
REQ-022 Changes on ADDR, WE or WDATA after accept SHALL be ignored until the next accept.

Reset
REQ-023 While RESET_N=0, the block SHALL force state IDLE, READY=0, RDATA=0, DISP_VALID=0, DISP_DATA=0, KBSR[15]=0 and counter=0.
REQ-024 Reset asserted mid-access SHALL abort the access with no write commit.
REQ-025 Array contents SHALL NOT be reset.
REQ-026 After reset deasserts with CS already high, the access SHALL be accepted on the first edge.

Configuration
REQ-027 Macro LC3_MMIO_EN, when defined, SHALL decode xFE00 as KBSR, xFE02 as KBDR, xFE04 as DSR and xFE06 as DDR ahead of the array; MMIO accesses use latency 1 regardless of MEM_LAT.
REQ-028 With LC3_MMIO_EN defined: KB_VALID=1 SHALL load KBDR[7:0] and set KBSR[15]; a read of KBDR clears KBSR[15] on DONE; if KB_VALID arrives in the same cycle, set wins.
REQ-029 With LC3_MMIO_EN defined: DSR reads SHALL return x8000; a write to DDR drives DISP_DATA=WDATA[7:0] and pulses DISP_VALID for one cycle on DONE.
REQ-030 Without LC3_MMIO_EN, those addresses SHALL map to the array, KB inputs are ignored, and DISP_DATA/DISP_VALID are tied to 0.

Structure
REQ-031 Package lc3_mem_pkg SHALL hold the state enum, the MMIO address constants and the x8000 DSR value.
REQ-032 Sub-module lc3_mem_array SHALL implement a single-port synchronous RAM (one write port, registered read) instantiated once.

Verification
REQ-033 Write then read: write x1234 @x0040 with MEM_LAT=3, then read @x0040 -> READY 4 cycles after accept each time; RDATA=x1234.
REQ-034 Wrap-around: with ADDR_BITS=12, write xBEEF @x1005 -> a read @x0005 returns xBEEF.
REQ-035 Abort: CS drops in cycle 2 of a write xAAAA @x0010 -> no READY; a read @x0010 returns the old value.
REQ-036 Held CS: CS held high for 3 cycles after READY -> no second READY until CS goes low then high.
REQ-037 Reset mid-write: RESET_N pulsed low during BUSY -> READY=0, state IDLE, no commit.
REQ-038 With LC3_MMIO_EN: KB_VALID with x41 -> KBSR reads x8000, KBDR reads x0041, then KBSR reads x0000; a write of x0048 to xFE06 -> DISP_DATA=x48 with a 1-cycle DISP_VALID.
